// File: rtl/eer_pkg.sv
// Shared constants and types for the EER-RL packet path.
// The receiver and its testbench use these definitions.
package eer_pkg;

    localparam int unsigned WORD_WIDTH = 16;
    localparam logic [WORD_WIDTH-1:0] BCAST_ID = 16'hFFFF;

    typedef enum logic [2:0] {
        HB   = 3'd0,
        CHE  = 3'd1,
        INV  = 3'd2,
        JOIN = 3'd3,
        DATA = 3'd4,
        ACK  = 3'd5
    } pkt_type_t;

    localparam int unsigned FLD_SRC    = 0;
    localparam int unsigned FLD_DST    = 1;
    localparam int unsigned FLD_HOPS   = 2;
    localparam int unsigned FLD_Q      = 3;
    localparam int unsigned FLD_ENERGY = 4;
    localparam int unsigned FLD_CH     = 5;
    localparam int unsigned FLD_CHHOPS = 6;
    localparam int unsigned FLD_TS     = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIELDS = 2'd1,
        CHK    = 2'd2,
        HOLD   = 2'd3
    } rx_state_t;

endpackage

// File: rtl/eer_sat_counter.sv
// Saturating up-counter used for the receiver statistics.
module eer_sat_counter #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/eer_pkt_receiver.sv
// Word-serial packet deframer: checks header, checksum and address filter,
// then holds the decoded fields on the f* bus until the consumer acknowledges.
module eer_pkt_receiver
    import eer_pkg::*;
#(
    parameter int unsigned              WORD_WIDTH = eer_pkg::WORD_WIDTH,
    parameter int unsigned              NUM_FIELDS = 8,
    parameter logic [WORD_WIDTH-1:0]    BCAST_ID   = eer_pkg::BCAST_ID,
    parameter int unsigned              CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  rx_sop,
    input  logic [WORD_WIDTH-1:0] rx_data,
    output logic                  pkt_valid,
    input  logic                  pkt_ack,
    output logic [2:0]            fPacketType,
    output logic [WORD_WIDTH-1:0] fSourceID,
    output logic [WORD_WIDTH-1:0] fDestinationID,
    output logic [WORD_WIDTH-1:0] fSourceHops,
    output logic [WORD_WIDTH-1:0] fQValue,
    output logic [WORD_WIDTH-1:0] fEnergyLeft,
    output logic [WORD_WIDTH-1:0] fChosenCH,
    output logic [WORD_WIDTH-1:0] fHopsFromCH,
    output logic [WORD_WIDTH-1:0] fTimeslot,
    output logic                  iAmDestination,
    output logic                  isBroadcast,
    output logic [CNT_WIDTH-1:0]  cnt_ok,
    output logic [CNT_WIDTH-1:0]  cnt_drop,
    output logic [CNT_WIDTH-1:0]  cnt_err
);

    localparam int unsigned IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

    rx_state_t             state_q, state_d;
    logic [IDX_W-1:0]      idx_q;
    logic [WORD_WIDTH-1:0] acc_q;
    logic [2:0]            type_q;
    logic [WORD_WIDTH-1:0] shadow_q [NUM_FIELDS];
    logic [WORD_WIDTH-1:0] fld_q    [NUM_FIELDS];
    logic [2:0]            out_type_q;
    logic                  dest_q, bcast_q;

    logic hs, sum_bad, type_bad, echo, foreign, accept;
    logic inc_ok, inc_drop, inc_err;

    assign hs       = rx_valid & rx_ready;
    assign sum_bad  = (acc_q ^ rx_data) != '0;
    assign type_bad = type_q >= 3'd6;
    assign echo     = shadow_q[FLD_SRC] == myNodeID;
    assign foreign  = (shadow_q[FLD_DST] != myNodeID) && (shadow_q[FLD_DST] != BCAST_ID);
    assign accept   = !sum_bad && !type_bad && !echo && !foreign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (hs && rx_sop) state_d = FIELDS;
            FIELDS: if (hs && !rx_sop && idx_q == LAST_IDX) state_d = CHK;
            CHK: begin
                if (hs) begin
                    if (rx_sop)      state_d = FIELDS;
                    else if (accept) state_d = HOLD;
                    else             state_d = IDLE;
                end
            end
            HOLD:   if (en && pkt_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_ready  = en & ~rst & (state_q != HOLD);
        pkt_valid = state_q == HOLD;
        inc_ok    = 1'b0;
        inc_drop  = 1'b0;
        inc_err   = 1'b0;
        if (hs) begin
            if (state_q == FIELDS) begin
                inc_err = rx_sop;
            end else if (state_q == CHK) begin
                if (rx_sop || sum_bad || type_bad) inc_err = 1'b1;
                else if (echo || foreign)          inc_drop = 1'b1;
                else                               inc_ok = 1'b1;
            end
        end
    end

    // Shadow fields fill during reception; outputs copy only on an accepted packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            acc_q      <= '0;
            type_q     <= '0;
            out_type_q <= '0;
            dest_q     <= 1'b0;
            bcast_q    <= 1'b0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                shadow_q[i] <= '0;
                fld_q[i]    <= '0;
            end
        end else if (hs) begin
            if (rx_sop) begin
                type_q <= rx_data[WORD_WIDTH-1 -: 3];
                acc_q  <= rx_data;
                idx_q  <= '0;
            end else if (state_q == FIELDS) begin
                shadow_q[idx_q] <= rx_data;
                acc_q           <= acc_q ^ rx_data;
                idx_q           <= idx_q + IDX_W'(1);
            end else if (state_q == CHK && accept) begin
                for (int i = 0; i < NUM_FIELDS; i++) fld_q[i] <= shadow_q[i];
                out_type_q <= type_q;
                dest_q     <= (shadow_q[FLD_DST] == myNodeID) && (shadow_q[FLD_DST] != BCAST_ID);
                bcast_q    <= shadow_q[FLD_DST] == BCAST_ID;
            end
        end
    end

    assign fPacketType    = out_type_q;
    assign fSourceID      = fld_q[FLD_SRC];
    assign fDestinationID = fld_q[FLD_DST];
    assign fSourceHops    = fld_q[FLD_HOPS];
    assign fQValue        = fld_q[FLD_Q];
    assign fEnergyLeft    = fld_q[FLD_ENERGY];
    assign fChosenCH      = fld_q[FLD_CH];
    assign fHopsFromCH    = fld_q[FLD_CHHOPS];
    assign fTimeslot      = fld_q[FLD_TS];
    assign iAmDestination = dest_q;
    assign isBroadcast    = bcast_q;

    eer_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_ok (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_ok),
        .count (cnt_ok)
    );

    eer_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_drop (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_drop),
        .count (cnt_drop)
    );

    eer_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_err (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_err),
        .count (cnt_err)
    );

endmodule

// File: tb/tb_eer_pkt_receiver.sv
// Directed scoreboard bench for eer_pkt_receiver: stimulus pushes expected
// packets, a monitor pops and compares whenever pkt_valid rises.
module tb_eer_pkt_receiver;

    typedef logic [7:0][15:0] flds_t;

    typedef struct {
        logic [2:0] typ;
        flds_t      f;
        logic       dest;
        logic       bcast;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [15:0] myNodeID = 16'h000C;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        rx_sop = 1'b0;
    logic [15:0] rx_data = '0;
    logic        pkt_valid;
    logic        pkt_ack = 1'b0;
    logic [2:0]  fPacketType;
    logic [15:0] fSourceID, fDestinationID, fSourceHops, fQValue;
    logic [15:0] fEnergyLeft, fChosenCH, fHopsFromCH, fTimeslot;
    logic        iAmDestination, isBroadcast;
    logic [7:0]  cnt_ok, cnt_drop, cnt_err;

    int   total = 0;
    int   bad = 0;
    exp_t sb [$];
    logic pv_prev = 1'b0;

    always #5 clk = ~clk;

    eer_pkt_receiver dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .myNodeID       (myNodeID),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_sop         (rx_sop),
        .rx_data        (rx_data),
        .pkt_valid      (pkt_valid),
        .pkt_ack        (pkt_ack),
        .fPacketType    (fPacketType),
        .fSourceID      (fSourceID),
        .fDestinationID (fDestinationID),
        .fSourceHops    (fSourceHops),
        .fQValue        (fQValue),
        .fEnergyLeft    (fEnergyLeft),
        .fChosenCH      (fChosenCH),
        .fHopsFromCH    (fHopsFromCH),
        .fTimeslot      (fTimeslot),
        .iAmDestination (iAmDestination),
        .isBroadcast    (isBroadcast),
        .cnt_ok         (cnt_ok),
        .cnt_drop       (cnt_drop),
        .cnt_err        (cnt_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic flds_t mk(input logic [15:0] src, dst, hops, q, e, ch, chh, ts);
        flds_t f;
        f[0] = src; f[1] = dst; f[2] = hops; f[3] = q;
        f[4] = e;   f[5] = ch;  f[6] = chh;  f[7] = ts;
        return f;
    endfunction

    task automatic send_word(input logic [15:0] d, input logic sop);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = d;
        rx_sop   = sop;
        @(negedge clk);
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("handshake_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_sop   = 1'b0;
    endtask

    // pause_at >= 0 drops en for three cycles before payload word pause_at.
    task automatic send_pkt(input logic [2:0] typ, input flds_t f, input logic flip,
                            input logic expect_ok, input logic dest, input logic bcast,
                            input int pause_at);
        logic [15:0] hdr;
        logic [15:0] sum;
        exp_t        e;
        hdr = {typ, 13'b0};
        sum = hdr;
        for (int i = 0; i < 8; i++) sum = sum ^ f[i];
        if (flip) sum = sum ^ 16'h0001;
        if (expect_ok) begin
            e.typ = typ; e.f = f; e.dest = dest; e.bcast = bcast;
            sb.push_back(e);
        end
        send_word(hdr, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i == pause_at) begin
                en = 1'b0;
                rx_valid = 1'b1;
                rx_data = 16'hDEAD;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("en_low_ready", {31'b0, rx_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
                en = 1'b1;
            end
            send_word(f[i], 1'b0);
        end
        send_word(sum, 1'b0);
        check("pkt_valid_after_chk", {31'b0, pkt_valid}, {31'b0, expect_ok});
    endtask

    task automatic ack_pkt();
        pkt_ack = 1'b1;
        @(posedge clk);
        #1;
        pkt_ack = 1'b0;
        check("pkt_valid_after_ack", {31'b0, pkt_valid}, 32'd0);
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pkt_valid && !pv_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_pkt", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("fPacketType", {29'b0, fPacketType}, {29'b0, e.typ});
                    check("fSourceID", {16'b0, fSourceID}, {16'b0, e.f[0]});
                    check("fDestinationID", {16'b0, fDestinationID}, {16'b0, e.f[1]});
                    check("fSourceHops", {16'b0, fSourceHops}, {16'b0, e.f[2]});
                    check("fQValue", {16'b0, fQValue}, {16'b0, e.f[3]});
                    check("fEnergyLeft", {16'b0, fEnergyLeft}, {16'b0, e.f[4]});
                    check("fChosenCH", {16'b0, fChosenCH}, {16'b0, e.f[5]});
                    check("fHopsFromCH", {16'b0, fHopsFromCH}, {16'b0, e.f[6]});
                    check("fTimeslot", {16'b0, fTimeslot}, {16'b0, e.f[7]});
                    check("iAmDestination", {31'b0, iAmDestination}, {31'b0, e.dest});
                    check("isBroadcast", {31'b0, isBroadcast}, {31'b0, e.bcast});
                end
            end
            pv_prev = pkt_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        check("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
        check("rst_pkt_valid", {31'b0, pkt_valid}, 32'd0);
        check("rst_cnt_ok", {24'b0, cnt_ok}, 32'd0);
        check("rst_fSourceID", {16'b0, fSourceID}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Good unicast DATA packet
        send_pkt(3'd4, mk(16'h0003, 16'h000C, 16'd1, 16'h0100, 16'h8000, 16'h0003, 16'd1, 16'd2),
                 1'b0, 1'b1, 1'b1, 1'b0, -1);
        check("ok_after_unicast", {24'b0, cnt_ok}, 32'd1);

        // Hold with back-pressure
        rx_valid = 1'b1;
        rx_sop = 1'b1;
        rx_data = 16'h2000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rx_ready", {31'b0, rx_ready}, 32'd0);
            check("hold_fTimeslot", {16'b0, fTimeslot}, 32'd2);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_sop = 1'b0;
        pkt_ack = 1'b1;
        @(posedge clk);
        #1;
        pkt_ack = 1'b0;
        check("release_pkt_valid", {31'b0, pkt_valid}, 32'd0);
        check("release_rx_ready", {31'b0, rx_ready}, 32'd1);

        // Broadcast heartbeat
        send_pkt(3'd0, mk(16'h0001, 16'hFFFF, 16'd2, 16'h0055, 16'h1234, 16'h0001, 16'd0, 16'd5),
                 1'b0, 1'b1, 1'b0, 1'b1, -1);
        check("ok_after_bcast", {24'b0, cnt_ok}, 32'd2);
        ack_pkt();

        // Address filtering
        send_pkt(3'd4, mk(16'h0005, 16'h0007, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6),
                 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check("drop_foreign", {24'b0, cnt_drop}, 32'd1);
        check("keep_fSourceID", {16'b0, fSourceID}, 32'h0001);
        send_pkt(3'd4, mk(16'h000C, 16'h000C, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6),
                 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check("drop_echo", {24'b0, cnt_drop}, 32'd2);
        check("keep_isBroadcast", {31'b0, isBroadcast}, 32'd1);

        // Checksum error
        send_pkt(3'd4, mk(16'h0003, 16'h000C, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6),
                 1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("err_checksum", {24'b0, cnt_err}, 32'd1);

        // Abort at payload word 4, then a full good packet
        send_word(16'h8000, 1'b1);
        send_word(16'h0003, 1'b0);
        send_word(16'h000C, 1'b0);
        send_word(16'h0001, 1'b0);
        send_pkt(3'd5, mk(16'h0009, 16'h000C, 16'd3, 16'h0200, 16'h4000, 16'h0009, 16'd0, 16'd7),
                 1'b0, 1'b1, 1'b1, 1'b0, -1);
        check("err_abort", {24'b0, cnt_err}, 32'd2);
        check("ok_after_abort", {24'b0, cnt_ok}, 32'd3);
        ack_pkt();

        // Reserved type
        send_pkt(3'd6, mk(16'h0003, 16'h000C, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6),
                 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check("err_type", {24'b0, cnt_err}, 32'd3);
        check("type_no_ok", {24'b0, cnt_ok}, 32'd3);

        // Asynchronous reset mid-packet
        send_word(16'h8000, 1'b1);
        send_word(16'h0003, 1'b0);
        send_word(16'h000C, 1'b0);
        send_word(16'h0001, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_fSourceID", {16'b0, fSourceID}, 32'd0);
        check("arst_fPacketType", {29'b0, fPacketType}, 32'd0);
        check("arst_isBroadcast", {31'b0, isBroadcast}, 32'd0);
        check("arst_cnt_ok", {24'b0, cnt_ok}, 32'd0);
        check("arst_cnt_err", {24'b0, cnt_err}, 32'd0);
        check("arst_rx_ready", {31'b0, rx_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Post-reset packet with an enable pause mid-payload
        send_pkt(3'd3, mk(16'h0002, 16'h000C, 16'd4, 16'h0010, 16'h0F00, 16'h0002, 16'd1, 16'd3),
                 1'b0, 1'b1, 1'b1, 1'b0, 3);
        check("ok_after_reset", {24'b0, cnt_ok}, 32'd1);
        check("err_after_reset", {24'b0, cnt_err}, 32'd0);
        ack_pkt();

        // Drop counter saturation
        for (int i = 0; i < 300; i++) begin
            send_pkt(3'd1, mk(16'h0005, 16'h0007, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0),
                     1'b0, 1'b0, 1'b0, 1'b0, -1);
        end
        check("drop_saturated", {24'b0, cnt_drop}, 32'd255);
        check("ok_unchanged", {24'b0, cnt_ok}, 32'd1);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eer_pkt_receiver.md
Name: eer_pkt_receiver

Overview:
- Receive-side deframer for the EER-RL node. It accepts a 16-bit word-serial packet stream from the radio interface and checks the header, checksum and address filter.
- It latches the decoded fields onto the f* bus that reward, KCH, QTUFMB and the neighbour table consume.
- It is the mirror of the reward block's r* transmit fields: same packet layout, opposite direction.
- A held-output handshake keeps the f* fields stable until the consumer FSM acknowledges them.

Parameters:
- WORD_WIDTH, 16, data/field width.
- NUM_FIELDS, 8, payload words per packet.
- BCAST_ID, 16'hFFFF, broadcast destination ID.
- CNT_WIDTH, 8, width of the saturating statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  receiver enable; when 0, rx_ready=0 and the FSM holds.
- myNodeID  in  WORD_WIDTH  own node ID.
- rx_valid  in  1  stream word valid.
- rx_ready  out  1  stream word accepted when rx_valid&rx_ready.
- rx_sop  in  1  marks the header word.
- rx_data  in  WORD_WIDTH  stream word.
- pkt_valid  out  1  decoded packet held on the f* outputs.
- pkt_ack  in  1  consumer releases the held packet.
- fPacketType  out  3  header[15:13].
- fSourceID, fDestinationID, fSourceHops, fQValue, fEnergyLeft, fChosenCH, fHopsFromCH, fTimeslot  out  WORD_WIDTH each  payload words 1..8, in that order.
- iAmDestination  out  1  fDestinationID==myNodeID (excludes broadcast).
- isBroadcast  out  1  fDestinationID==BCAST_ID.
- cnt_ok, cnt_drop, cnt_err  out  CNT_WIDTH each  saturating statistics counters.

Behaviour:
- Packet format, one word per handshake:
  - Word 0: header = {type[2:0], 13'b0}.
  - Words 1..8: payload fields, in the port order above.
  - Word 9: checksum = XOR of words 0..8.
- Reset (asynchronous, rst=1):
  - state=IDLE.
  - All f* outputs 0.
  - pkt_valid, iAmDestination, isBroadcast = 0.
  - All counters 0.
  - rx_ready=0 while rst is high.
  - Reset asserted mid-packet discards the partial packet; no counter changes.
- rx_ready = en & (state!=HOLD).
- IDLE: on a handshake with rx_sop=1, latch the type, seed the XOR accumulator with the word, set idx=0, go to FIELDS. Handshake words with rx_sop=0 are discarded silently.
- FIELDS: each handshake stores rx_data into the shadow field[idx] and XORs it into the accumulator. idx=NUM_FIELDS-1 → CHK.
- CHK: on the checksum handshake, evaluate in this order:
  - acc^rx_data!=0 → cnt_err+1, go to IDLE.
  - Otherwise type>=6 → cnt_err+1, go to IDLE.
  - Otherwise fSourceID==myNodeID (own echo) → cnt_drop+1, go to IDLE.
  - Otherwise destination not in {myNodeID, BCAST_ID} → cnt_drop+1, go to IDLE.
  - Otherwise copy the shadow fields to the f* outputs, cnt_ok+1, go to HOLD.
- Latency: f*, iAmDestination, isBroadcast and pkt_valid all become valid in the cycle after the checksum handshake.
- HOLD: pkt_valid=1 and the f* outputs are stable. On pkt_ack=1, pkt_valid drops in the next cycle and the state goes to IDLE. rx_ready=0 throughout HOLD, so back-pressure applies.
- pkt_ack outside HOLD is ignored.
- f* outputs keep their last accepted packet until the next accepted packet. Dropped or errored packets never update them.
- rx_sop=1 on a handshake in FIELDS or CHK:
  - Abort the current packet, cnt_err+1.
  - Treat the word as a new header: reseed the accumulator, idx=0, go to FIELDS.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- en=0 mid-packet: the FSM freezes with its state and index preserved; reception resumes when en=1.
- Shadow field registers are distinct from the output registers, so a new packet can never corrupt a held one.

Decomposition:
- Shared package eer_pkg:
  - WORD_WIDTH constant.
  - pkt_type_t enum: HB=0, CHE=1, INV=2, JOIN=3, DATA=4, ACK=5.
  - Field index constants FLD_SRC..FLD_TS (0..7).
  - BCAST_ID constant.
  - Receiver state enum {IDLE, FIELDS, CHK, HOLD}.
- One sub-module, eer_sat_counter (CNT_WIDTH parameter, inc input, saturating), instantiated three times.

Test Plan:
- Good unicast: myNodeID=16'h000C. Send header 16'h8000 (type 4), fields src=0x0003, dst=0x000C, hops=1, q=0x0100, E=0x8000, CH=0x0003, chHops=1, ts=2, then the correct checksum → pkt_valid=1 one cycle after the checksum, fPacketType=4, iAmDestination=1, isBroadcast=0, cnt_ok=1.
- Hold/back-pressure: after the above, keep rx_valid=1 without pkt_ack for 5 cycles → rx_ready=0, f* unchanged. Assert pkt_ack → pkt_valid=0 in the next cycle, rx_ready=1.
- Broadcast heartbeat: type 0, dst=0xFFFF, src=0x0001 → pkt_valid=1, isBroadcast=1, iAmDestination=0.
- Filtering: dst=0x0007 → cnt_drop=1, no pkt_valid, f* keep the previous packet. Then src=0x000C → cnt_drop=2.
- Errors: checksum word flipped in bit 0 → cnt_err=1. rx_sop asserted at payload word 4, followed by a full valid packet → cnt_err=2, the second packet is accepted, cnt_ok increments.
- Reset mid-packet and saturation: assert rst after word 3 → all outputs 0 asynchronously, next packet decodes normally. Send 300 dropped packets → cnt_drop=255.
